multi_word_reg_bank: RTL and testbench

Parametrised register bank that generalises the two-word, 16-bit bank to NUM_WORDS words of DATA_WIDTH bits each, with per-word write and read enables and a registered read path. It checks in hardware the rule that a read must not directly follow a write. Each violation raises a one-cycle flag and advances a saturating counter that software can clear. It sits behind the local bus decoder and is the storage used by peripheral configuration blocks.

---
 rtl/multi_word_reg_bank.sv | 95 +++++++++
 tb/tb_multi_word_reg_bank.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multi_word_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : multi_word_reg_bank
// Brief    : NUM_WORDS x DATA_WIDTH register bank with registered read path
//            and hardware detection of read-directly-after-write violations.
// Revision : 1.0 - initial release
// ============================================================================
module multi_word_reg_bank #(
    parameter int                    NUM_WORDS      = 2,
    parameter int                    DATA_WIDTH     = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int                    VIOL_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_WORDS-1:0]      write_enable,
    input  logic [NUM_WORDS-1:0]      read_enable,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic                      viol_clear,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      read_valid,
    output logic                      b2b_violation,
    output logic [VIOL_CNT_WIDTH-1:0] viol_count
);

    localparam logic [VIOL_CNT_WIDTH-1:0] c_CNT_MAX = {VIOL_CNT_WIDTH{1'b1}};
    localparam logic [VIOL_CNT_WIDTH-1:0] c_CNT_ONE = VIOL_CNT_WIDTH'(1);

    logic [NUM_WORDS-1:0][DATA_WIDTH-1:0] r_words;
    logic [DATA_WIDTH-1:0]                r_read_data;
    logic                                 r_read_valid;
    logic                                 r_b2b_violation;
    logic [VIOL_CNT_WIDTH-1:0]            r_viol_count;
    logic                                 r_wr_q;

    logic [DATA_WIDTH-1:0]                w_rd_data;
    logic                                 w_rd_req;
    logic                                 w_viol;

    assign w_rd_req = |read_enable;
    assign w_viol   = w_rd_req & r_wr_q;

    // Scan from the top so the lowest requested word wins; words are read
    // before this edge's write lands, giving read-before-write semantics.
    always_comb begin
        w_rd_data = r_read_data;
        for (int i = NUM_WORDS - 1; i >= 0; i--) begin
            if (read_enable[i]) begin
                w_rd_data = r_words[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_words[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (write_enable[i]) begin
                    r_words[i] <= write_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data     <= '0;
            r_read_valid    <= 1'b0;
            r_b2b_violation <= 1'b0;
            r_viol_count    <= '0;
            r_wr_q          <= 1'b0;
        end else begin
            r_read_data     <= w_rd_data;
            r_read_valid    <= w_rd_req;
            r_b2b_violation <= w_viol;
            r_wr_q          <= |write_enable;
            // Clear takes priority over a coincident violation.
            if (viol_clear) begin
                r_viol_count <= '0;
            end else if (w_viol && (r_viol_count != c_CNT_MAX)) begin
                r_viol_count <= r_viol_count + c_CNT_ONE;
            end
        end
    end

    assign read_data     = r_read_data;
    assign read_valid    = r_read_valid;
    assign b2b_violation = r_b2b_violation;
    assign viol_count    = r_viol_count;

endmodule
`default_nettype wire

// File: tb/tb_multi_word_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_word_reg_bank
// Brief    : Self-checking bench for multi_word_reg_bank (4 words, 2-bit counter).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_word_reg_bank;

    localparam int          NW  = 4;
    localparam int          DW  = 16;
    localparam int          VCW = 2;
    localparam logic [15:0] RV  = 16'h5A5A;
    localparam int          CNT_MAX = (1 << VCW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NW-1:0]   write_enable = '0;
    logic [NW-1:0]   read_enable = '0;
    logic [DW-1:0]   write_data = '0;
    logic            viol_clear = 1'b0;
    logic [DW-1:0]   read_data;
    logic            read_valid;
    logic            b2b_violation;
    logic [VCW-1:0]  viol_count;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    multi_word_reg_bank #(
        .NUM_WORDS(NW), .DATA_WIDTH(DW), .RESET_VALUE(RV), .VIOL_CNT_WIDTH(VCW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .write_enable(write_enable), .read_enable(read_enable),
        .write_data(write_data), .viol_clear(viol_clear),
        .read_data(read_data), .read_valid(read_valid),
        .b2b_violation(b2b_violation), .viol_count(viol_count)
    );

    always #5 clk = ~clk;

    // Reference model: an array of words plus "was there a write last cycle".
    logic [DW-1:0] m_mem [NW];
    logic [DW-1:0] m_rd;
    bit            m_rv;
    bit            m_viol;
    int            m_cnt;
    bit            m_wrote_last;

    function automatic int first_set(input logic [NW-1:0] v);
        for (int i = 0; i < NW; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) m_mem[i] <= RV;
            m_rd <= '0; m_rv <= 1'b0; m_viol <= 1'b0; m_cnt <= 0; m_wrote_last <= 1'b0;
        end else begin
            for (int i = 0; i < NW; i++) if (write_enable[i]) m_mem[i] <= write_data;
            if (first_set(read_enable) >= 0) m_rd <= m_mem[first_set(read_enable)];
            m_rv   <= (read_enable != 0);
            m_viol <= (read_enable != 0) && m_wrote_last;
            if (viol_clear) m_cnt <= 0;
            else if ((read_enable != 0) && m_wrote_last) m_cnt <= (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            m_wrote_last <= (write_enable != 0);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (read_data !== m_rd || read_valid !== m_rv || b2b_violation !== m_viol
                || int'(viol_count) !== m_cnt) begin
                bad++;
                $display("FAIL model @%0t: got rd=%h rv=%b viol=%b cnt=%0d, want rd=%h rv=%b viol=%b cnt=%0d",
                         $time, read_data, read_valid, b2b_violation, viol_count,
                         m_rd, m_rv, m_viol, m_cnt);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs; returns at the negedge after the capturing edge.
    task automatic step(input logic [NW-1:0] we, input logic [NW-1:0] re,
                        input logic [DW-1:0] wd, input logic clr);
        write_enable = we; read_enable = re; write_data = wd; viol_clear = clr;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset rd", int'(read_data), 0);
        check("reset valid", int'(read_valid), 0);
        check("reset cnt", int'(viol_count), 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        for (int i = 0; i < NW; i++) begin
            step('0, NW'(1 << i), '0, 1'b0);
            check("reset word", int'(read_data), int'(RV));
            check("read valid", int'(read_valid), 1);
        end
        step('0, '0, '0, 1'b0);
        check("valid drops", int'(read_valid), 0);
        check("cnt after reads", int'(viol_count), 0);

        step(4'b0001, '0, 16'h1600, 1'b0);
        step('0, '0, '0, 1'b0);
        step('0, 4'b0001, '0, 1'b0);
        check("gap read", int'(read_data), 16'h1600);
        check("gap no viol", int'(b2b_violation), 0);

        step(4'b0110, '0, 16'hABCD, 1'b0);
        step('0, 4'b0010, '0, 1'b0);
        check("b2b data", int'(read_data), 16'hABCD);
        check("b2b pulse", int'(b2b_violation), 1);
        check("b2b cnt", int'(viol_count), 1);
        step('0, '0, '0, 1'b0);
        check("pulse one cycle", int'(b2b_violation), 0);

        step(4'b0100, 4'b0100, 16'h1234, 1'b0);
        check("rbw old value", int'(read_data), 16'hABCD);
        step('0, '0, '0, 1'b0);
        step('0, 4'b0100, '0, 1'b0);
        check("rbw new value", int'(read_data), 16'h1234);
        step('0, 4'b1100, '0, 1'b0);
        check("lowest bit wins", int'(read_data), 16'h1234);

        step('0, '0, '0, 1'b1);
        check("clear", int'(viol_count), 0);
        for (int p = 0; p < 5; p++) begin
            step(4'b1000, '0, DW'(16'h0100 + p), 1'b0);
            step('0, 4'b1000, '0, 1'b0);
        end
        check("saturated", int'(viol_count), 3);
        check("sat data", int'(read_data), 16'h0104);
        step(4'b0001, '0, 16'hBEEF, 1'b0);
        step('0, 4'b0001, '0, 1'b1);
        check("clear wins", int'(viol_count), 0);
        check("pulse with clear", int'(b2b_violation), 1);

        step(4'b0010, '0, 16'h7777, 1'b0);
        write_enable = '0;
        rst_n = 1'b0;
        #2;
        check("async rd", int'(read_data), 0);
        check("async valid", int'(read_valid), 0);
        check("async viol", int'(b2b_violation), 0);
        @(negedge clk);
        read_enable = 4'b0010;
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset word", int'(read_data), int'(RV));
        check("post-reset no viol", int'(b2b_violation), 0);
        check("post-reset cnt", int'(viol_count), 0);
        step('0, '0, '0, 1'b0);
        chk_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
